// File: rtl/audio_pkg.sv
// audio_pkg: shared types, constants and helpers for the audio output stage.
//   sample_t     signed 8-bit audio sample
//   cap_state_t  capture FSM states
//   sat8()       clamp a 10-bit signed mix into sample_t
//   to_offset()  signed sample -> offset-binary PWM duty
package audio_pkg;

  typedef logic signed [7:0] sample_t;

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} cap_state_t;

  localparam int         SAMPLE_MAX = 127;
  localparam int         SAMPLE_MIN = -128;
  localparam logic [7:0] PWM_MID    = 8'd128;

  function automatic sample_t sat8(input logic signed [9:0] v);
    if (v > 10'(SAMPLE_MAX))      return 8'(SAMPLE_MAX);
    else if (v < 10'(SAMPLE_MIN)) return 8'(SAMPLE_MIN);
    else                          return v[7:0];
  endfunction

  // Flipping the sign bit maps -128..127 onto 0..255, so silence sits at midscale.
  function automatic logic [7:0] to_offset(input sample_t s);
    return {~s[7], s[6:0]};
  endfunction

endpackage

// File: rtl/audio_out_stage_pwm.sv
// pwm_dac: 8-bit PWM DAC with a period-aligned duty update.
//   clk_in        system clock
//   rst_n_in      async active-low reset
//   duty_load_in  1-cycle strobe: write duty_in into the shadow register
//   duty_in       offset-binary duty (0 = always low, 255 = 255/256 high)
//   pwm_out       registered PWM bit
module pwm_dac
  import audio_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       duty_load_in,
  input  logic [7:0] duty_in,
  output logic       pwm_out
);

  logic [7:0] cnt_q, shadow_q, duty_q;
  logic       pwm_q;

  // duty only follows shadow at the end of a period, so a period is never split.
  // A shadow write in that same cycle is seen one period later (NBA ordering).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q    <= '0;
      shadow_q <= PWM_MID;
      duty_q   <= PWM_MID;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
      if (duty_load_in)    shadow_q <= duty_in;
      if (cnt_q == 8'hFF)  duty_q   <= shadow_q;
      pwm_q <= (cnt_q < duty_q);
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/audio_out_stage.sv
// audio_out_stage: sample-rate step generator, channel capture, mixer and PWM out.
//   clk_in / rst_n_in   system clock, async active-low reset
//   step_out            1-cycle pulse every SAMPLE_DIV cycles (generator advance)
//   ch0_in / ch1_in     signed channel samples
//   vol_in              attenuation shift (mix >>> vol_in)
//   mute_in             force mixed sample to 0
//   sample_out          signed mixed sample, held between updates
//   sample_valid_out    1-cycle pulse when sample_out updates
//   pwm_out             1-bit PWM audio
module audio_out_stage
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV  = 8333,
  parameter int CAPTURE_DLY = 2
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  output logic       step_out,
  input  logic [7:0] ch0_in,
  input  logic [7:0] ch1_in,
  input  logic [1:0] vol_in,
  input  logic       mute_in,
  output logic [7:0] sample_out,
  output logic       sample_valid_out,
  output logic       pwm_out
);

  localparam logic [15:0] DIV_LAST  = 16'(SAMPLE_DIV - 1);
  localparam int          WW        = (CAPTURE_DLY > 1) ? $clog2(CAPTURE_DLY) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(CAPTURE_DLY - 1);
  localparam int          STAGES    = 3;

  // ---- divider ----
  logic [15:0] div_cnt_q, div_cnt_d;

  assign step_out  = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = step_out ? '0 : div_cnt_q + 16'd1;

  // ---- capture FSM ----
  cap_state_t    state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          cap_en;

  // Channel registers load on the edge that enters CAPTURE, i.e. once the
  // generators' phase and LUT registers have both settled after the step.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cap_en  = 1'b0;
    case (state_q)
      IDLE:    if (step_out) begin
                 state_d = WAIT;
                 wcnt_d  = '0;
               end
      WAIT:    if (wcnt_q == WAIT_LAST) begin
                 state_d = CAPTURE;
                 cap_en  = 1'b1;
               end else begin
                 wcnt_d = wcnt_q + WW'(1);
               end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- mix pipeline ----
  // vld_pipe[0]: CAPTURE cycle (S1), [1]: S2, [2]: S3, [3]: sample_out updated.
  logic [STAGES:0]   vld_pipe;
  sample_t           cap0_q, cap1_q, sample_q, sample_d;
  logic signed [9:0] sum_q, att_q;

  assign sample_d = mute_in ? sample_t'(0) : sat8(att_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt_q <= '0;
      state_q   <= IDLE;
      wcnt_q    <= '0;
      cap0_q    <= '0;
      cap1_q    <= '0;
      sum_q     <= '0;
      att_q     <= '0;
      sample_q  <= '0;
      vld_pipe  <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      if (cap_en) begin
        cap0_q <= ch0_in;
        cap1_q <= ch1_in;
      end
      sum_q    <= {{2{cap0_q[7]}}, cap0_q} + {{2{cap1_q[7]}}, cap1_q};
      att_q    <= sum_q >>> vol_in;
      if (vld_pipe[2]) sample_q <= sample_d;
      vld_pipe <= {vld_pipe[STAGES-1:0], cap_en};
    end
  end

  assign sample_out       = sample_q;
  assign sample_valid_out = vld_pipe[STAGES];

  pwm_dac u_pwm (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .duty_load_in (vld_pipe[2]),
    .duty_in      (to_offset(sample_d)),
    .pwm_out      (pwm_out)
  );

endmodule

// File: tb/tb_audio_out_stage.sv
// Directed bench for audio_out_stage. A short-divider instance carries the
// functional vectors (divider chosen so a later S3 write lands on pwm_cnt == 255);
// a default-parameter instance confirms the real sample-rate timing.
module tb_audio_out_stage;

  localparam int D = 877;

  logic       clk = 1'b0;
  logic       rst_n, rst_def_n;
  logic [7:0] ch0, ch1;
  logic [1:0] vol;
  logic       mute;
  logic       step, valid, pwm;
  logic [7:0] smp;
  logic       def_step, def_valid, def_pwm;
  logic [7:0] def_smp;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // posedges since last reset release == pwm_cnt / div_cnt phase
  bit def_done = 1'b0;

  always #5 clk = ~clk;

  audio_out_stage #(.SAMPLE_DIV(D), .CAPTURE_DLY(2)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .step_out(step),
    .ch0_in(ch0), .ch1_in(ch1), .vol_in(vol), .mute_in(mute),
    .sample_out(smp), .sample_valid_out(valid), .pwm_out(pwm)
  );

  audio_out_stage u_def (
    .clk_in(clk), .rst_n_in(rst_def_n), .step_out(def_step),
    .ch0_in(ch0), .ch1_in(ch1), .vol_in(vol), .mute_in(mute),
    .sample_out(def_smp), .sample_valid_out(def_valid), .pwm_out(def_pwm)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_step(input string tag);
    int n = 0;
    while (!step && n < 2000) begin
      tick();
      n++;
    end
    if (!step) chk({tag, "_step_timeout"}, int'(step), 1);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!valid && n < 20);
    chk({tag, "_latency"}, n, 6);
  endtask

  task automatic do_sample(input string tag, input int exp);
    wait_step(tag);
    wait_valid(tag);
    chk({tag, "_sample"}, int'($signed(smp)), exp);
  endtask

  // Step to the cycle right after the next pwm_cnt == 255.
  task automatic align();
    do tick(); while (cyc % 256 != 0);
  endtask

  task automatic pwm_hi(output int hi);
    hi = 0;
    repeat (256) begin
      tick();
      hi += int'(pwm);
    end
  endtask

  initial begin
    int hi, vc;
    rst_n = 1'b0;
    ch0 = 8'd40; ch1 = 8'hF6; vol = 2'd0; mute = 1'b0;
    repeat (10) tick();
    chk("rst_step",   int'(step), 0);
    chk("rst_sample", int'($signed(smp)), 0);
    chk("rst_valid",  int'(valid), 0);
    chk("rst_pwm",    int'(pwm), 0);
    rst_n = 1'b1;
    cyc   = 0;

    // 40 + (-10) = 30 -> duty 158
    wait_step("first");
    chk("first_step_cyc", cyc, D - 1);
    wait_valid("mix");
    chk("mix_sample", int'($signed(smp)), 30);
    tick();
    chk("mix_valid_pulse", int'(valid), 0);
    align(); pwm_hi(hi); chk("mix_pwm_hi", hi, 158);

    ch0 = 8'd127; ch1 = 8'd127;
    do_sample("sat_pos", 127);
    align(); pwm_hi(hi); chk("sat_pos_pwm_hi", hi, 255);

    ch0 = 8'h80; ch1 = 8'h80;
    do_sample("sat_neg", -128);
    align(); pwm_hi(hi); chk("sat_neg_pwm_hi", hi, 0);

    ch0 = 8'd127; ch1 = 8'd127; vol = 2'd1;
    do_sample("vol1", 127);

    ch0 = 8'h9C; ch1 = 8'd0; vol = 2'd2;   // -100 >>> 2 = -25 -> duty 103
    do_sample("att", -25);
    align(); pwm_hi(hi); chk("att_pwm_hi", hi, 103);

    mute = 1'b1;
    do_sample("mute", 0);
    align(); pwm_hi(hi); chk("mute_pwm_hi", hi, 128);

    // 7th sample: S3 cycle is 7*D+4 = 6143, pwm_cnt == 255.
    mute = 1'b0; ch0 = 8'd60; ch1 = 8'd0; vol = 2'd0;
    do_sample("bnd", 60);
    pwm_hi(hi); chk("bnd_old_period", hi, 128);
    pwm_hi(hi); chk("bnd_new_period", hi, 188);

    // Reset one cycle after step (in WAIT).
    wait_step("rst_wait");
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst2_sample", int'($signed(smp)), 0);
    chk("rst2_valid",  int'(valid), 0);
    chk("rst2_pwm",    int'(pwm), 0);
    chk("rst2_step",   int'(step), 0);
    tick(); tick();
    rst_n = 1'b1;
    cyc   = 0;
    vc    = 0;
    repeat (20) begin
      tick();
      vc += int'(valid);
    end
    chk("rst2_no_valid", vc, 0);
    wait_step("restart");
    chk("restart_step_cyc", cyc, D - 1);
    wait_valid("restart");
    chk("restart_sample", int'($signed(smp)), 60);

    while (!def_done) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Default-parameter timing: first step at 8332, valid 6 cycles later.
  initial begin
    int n;
    rst_def_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("def_rst_step",   int'(def_step), 0);
    chk("def_rst_sample", int'($signed(def_smp)), 0);
    chk("def_rst_valid",  int'(def_valid), 0);
    rst_def_n = 1'b1;
    n = 0;
    while (!def_step && n < 9000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("def_first_step", n, 8332);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!def_valid && n < 20);
    chk("def_latency", n, 6);
    def_done = 1'b1;
  end

endmodule
